// File: rtl/fb_pkg.sv
// Frame-buffer geometry and 640x480@60 VGA timing shared by the scan-out reader
// and the line-drawing datapath.
package fb_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned FB_W    = 320;
    localparam int unsigned FB_H    = 240;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned FB_SIZE = FB_W * FB_H;

    localparam int unsigned CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // Sync/blank bundle as seen on the pins (all active-low).
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic blank_n;
    } vga_ctl_t;

    localparam vga_ctl_t VGA_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

    function automatic logic is_active(cnt_t h, cnt_t v);
        return (h < cnt_t'(H_ACTIVE)) && (v < cnt_t'(V_ACTIVE));
    endfunction

    function automatic vga_ctl_t decode_ctl(cnt_t h, cnt_t v);
        vga_ctl_t c;
        c.blank_n = is_active(h, v);
        c.hs_n    = !((h >= cnt_t'(H_ACTIVE + H_FP)) && (h < cnt_t'(H_ACTIVE + H_FP + H_SYNC)));
        c.vs_n    = !((v >= cnt_t'(V_ACTIVE + V_FP)) && (v < cnt_t'(V_ACTIVE + V_FP + V_SYNC)));
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider, h/v raster counters, sync/blank decode and frame-start pulse.
// Counters sit at (0,0) whenever stopped; the first running clock re-enters (0,0).
module vga_timing_gen
    import fb_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     i_enable,
    output logic     o_tick,
    output cnt_t     o_h_cnt,
    output cnt_t     o_v_cnt,
    output logic     o_line_end,
    output logic     o_frame_end,
    output vga_ctl_t o_ctl,
    output logic     o_next_active,
    output logic     o_frame_start
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_d;
    cnt_t             r_h_cnt;
    cnt_t             w_h_d;
    cnt_t             r_v_cnt;
    cnt_t             w_v_d;
    logic             r_run;
    logic             r_frame_start;
    logic             w_tick;
    logic             w_line_end;
    logic             w_frame_end;

    assign w_tick      = r_run && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_line_end  = (r_h_cnt == cnt_t'(H_TOTAL - 1));
    assign w_frame_end = w_line_end && (r_v_cnt == cnt_t'(V_TOTAL - 1));

    always_comb begin
        w_div_d = r_div;
        w_h_d   = r_h_cnt;
        w_v_d   = r_v_cnt;
        // The restart clock (enable high, not yet running) also stays at (0,0) so
        // pixel (0,0) gets a full CLK_DIV period after frame_start.
        if (i_reset || !i_enable || !r_run) begin
            w_div_d = '0;
            w_h_d   = '0;
            w_v_d   = '0;
        end else if (w_tick) begin
            w_div_d = '0;
            if (w_line_end) begin
                w_h_d = '0;
                w_v_d = w_frame_end ? '0 : r_v_cnt + 1'b1;
            end else begin
                w_h_d = r_h_cnt + 1'b1;
            end
        end else begin
            w_div_d = r_div + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div         <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_run         <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_d;
            r_h_cnt       <= w_h_d;
            r_v_cnt       <= w_v_d;
            r_run         <= i_enable;
            r_frame_start <= i_enable && (!r_run || (w_tick && w_frame_end));
        end
    end

    assign o_tick        = w_tick;
    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_line_end    = w_line_end;
    assign o_frame_end   = w_frame_end;
    assign o_ctl         = decode_ctl(r_h_cnt, r_v_cnt);
    assign o_next_active = !i_reset && i_enable && is_active(w_h_d, w_v_d);
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/fb_scanout_reader.sv
// Frame-buffer scan-out: pixel-doubled read addressing for a 320x240 buffer on a
// 640x480 raster, plus the one-pixel output pipeline aligning RGB with sync/blank.
module fb_scanout_reader
    import fb_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned FB_W       = fb_pkg::FB_W,
    parameter int unsigned FB_H       = fb_pkg::FB_H,
    parameter int unsigned ADDR_W     = fb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              red_in,
    input  logic              green_in,
    input  logic              blue_in,
    output logic              FB_RE,
    output logic [ADDR_W-1:0] FB_rd_addr,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              red_out,
    output logic              green_out,
    output logic              blue_out,
    output logic              frame_start
);

    if (RD_LATENCY >= CLK_DIV) begin : g_bad_latency
        $error("fb_scanout_reader: RD_LATENCY must be less than CLK_DIV");
    end

    if (FB_W * FB_H > (1 << ADDR_W)) begin : g_bad_addr_w
        $error("fb_scanout_reader: ADDR_W too narrow for FB_W*FB_H");
    end

    logic              w_tick;
    cnt_t              w_h_cnt;
    cnt_t              w_v_cnt;
    logic              w_line_end;
    logic              w_frame_end;
    vga_ctl_t          w_ctl;
    logic              w_next_active;
    logic              w_frame_start;
    logic              w_stop;

    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] w_col_d;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] w_row_base_d;
    logic [ADDR_W-1:0] r_addr;
    logic              r_fb_re;
    vga_ctl_t          r_ctl;
    logic              r_red;
    logic              r_green;
    logic              r_blue;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_enable      (enable),
        .o_tick        (w_tick),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_line_end    (w_line_end),
        .o_frame_end   (w_frame_end),
        .o_ctl         (w_ctl),
        .o_next_active (w_next_active),
        .o_frame_start (w_frame_start)
    );

    assign w_stop = reset || !enable;

    // Column advances after each odd active pixel and row base after each odd active
    // line, so every buffer pixel covers a 2x2 block of the raster.
    always_comb begin
        w_col_d      = r_col;
        w_row_base_d = r_row_base;
        if (w_stop) begin
            w_col_d      = '0;
            w_row_base_d = '0;
        end else if (w_tick) begin
            if (w_line_end) begin
                w_col_d = '0;
                if (w_frame_end) begin
                    w_row_base_d = '0;
                end else if (w_v_cnt[0] && (w_v_cnt < cnt_t'(V_ACTIVE - 1))) begin
                    w_row_base_d = r_row_base + ADDR_W'(FB_W);
                end
            end else if (w_h_cnt[0] && (w_h_cnt < cnt_t'(H_ACTIVE - 1))) begin
                w_col_d = r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col      <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
            r_fb_re    <= 1'b0;
        end else begin
            r_col      <= w_col_d;
            r_row_base <= w_row_base_d;
            r_fb_re    <= w_next_active;
            if (!enable) begin
                r_addr <= '0;
            end else if (w_next_active) begin
                r_addr <= w_row_base_d + w_col_d;
            end
        end
    end

    // Captured on the tick closing pixel (h,v): read data has settled by then.
    always_ff @(posedge clk) begin
        if (w_stop) begin
            r_ctl   <= VGA_IDLE;
            r_red   <= 1'b0;
            r_green <= 1'b0;
            r_blue  <= 1'b0;
        end else if (w_tick) begin
            r_ctl   <= w_ctl;
            r_red   <= red_in & w_ctl.blank_n;
            r_green <= green_in & w_ctl.blank_n;
            r_blue  <= blue_in & w_ctl.blank_n;
        end
    end

    assign FB_RE       = r_fb_re;
    assign FB_rd_addr  = r_addr;
    assign vga_hs      = r_ctl.hs_n;
    assign vga_vs      = r_ctl.vs_n;
    assign vga_blank_n = r_ctl.blank_n;
    assign red_out     = r_red;
    assign green_out   = r_green;
    assign blue_out    = r_blue;
    assign frame_start = w_frame_start;

endmodule
